// File: rtl/wormhole_output_allocator.sv
// Wormhole output-port allocator for one output of the 5-port mesh router.
// Arbitrates header flits round-robin and holds the grant for the whole packet,
// until the tail flit moves. Flit movement is gated on downstream credits. A
// watchdog revokes a grant that stalls without moving a flit.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req             per-requester head-of-buffer valid (0=L 1=N 2=E 3=W 4=S)
//   flit_id         3-bit flit type per requester (001 header, 100 tail, else body)
//   timeout_cycles  watchdog limit in stalled cycles, 0 disables the watchdog
//   credit_return   downstream freed one slot this cycle
//   grant           one-hot crossbar select, or all zero
//   xfer            a flit moves this cycle (combinational)
//   busy            a packet currently owns this output
//   credits         current downstream credit count
//   timeout_err     one-cycle pulse after a watchdog revocation
//
// state  | meaning
// S_IDLE | no owner; arbitrate among header flits
// S_HOLD | r_gidx owns the output until its tail moves or the watchdog fires
module wormhole_output_allocator #(
  parameter int CREDITS = 4,
  parameter int NREQ    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] flit_id,
  input  logic [11:0]       timeout_cycles,
  input  logic              credit_return,
  output logic [NREQ-1:0]   grant,
  output logic              xfer,
  output logic              busy,
  output logic [3:0]        credits,
  output logic              timeout_err
);

  localparam logic [3:0] CRED_MAX  = 4'(CREDITS);
  localparam logic [2:0] FT_HEADER = 3'b001;
  localparam logic [2:0] FT_TAIL   = 3'b100;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_gidx;
  logic [2:0]  r_ptr;
  logic [11:0] r_wd;
  logic [3:0]  r_credits;
  logic        r_timeout_err;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic            w_found;
  logic [2:0]      w_sel;
  logic [2:0]      w_gflit;
  logic            w_xfer;
  logic            w_tail_xfer;
  logic            w_expire;
  logic [2:0]      w_ptr_inc;

  // Only header flits may start a packet.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req[i] && (flit_id[3*i +: 3] == FT_HEADER);
    end
  end

  // First eligible index at or after the pointer, wrapping past the last requester.
  always_comb begin
    logic [3:0] v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = {1'b0, r_ptr} + 4'(k);
      if (v_idx >= 4'(NREQ)) v_idx = v_idx - 4'(NREQ);
      if (!w_found && w_elig[v_idx[2:0]]) begin
        w_found = 1'b1;
        w_sel   = v_idx[2:0];
      end
    end
  end

  always_comb begin
    w_gflit = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gidx == 3'(i)) w_gflit = flit_id[3*i +: 3];
    end
  end

  assign w_tail_xfer = w_xfer && (w_gflit == FT_TAIL);
  // Expiry requires no xfer, so a tail moving on the expiry cycle wins.
  assign w_expire    = (r_state == S_HOLD) && !w_xfer && (timeout_cycles != 12'd0) &&
                       (r_wd == timeout_cycles - 12'd1);
  assign w_ptr_inc   = (r_gidx == 3'(NREQ - 1)) ? 3'd0 : r_gidx + 3'd1;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_gidx        <= '0;
      r_ptr         <= '0;
      r_wd          <= '0;
      r_credits     <= CRED_MAX;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timeout_err <= w_expire;

      if (r_state == S_IDLE) begin
        if (w_found) begin
          r_gidx <= w_sel;
          r_wd   <= '0;
        end
      end else begin
        if (w_tail_xfer || w_expire) begin
          r_ptr <= w_ptr_inc;
          r_wd  <= '0;
        end else if (w_xfer) begin
          r_wd <= '0;
        end else begin
          r_wd <= r_wd + 12'd1;
        end
      end

      if (w_xfer && !credit_return) begin
        r_credits <= r_credits - 4'd1;
      end else if (!w_xfer && credit_return && (r_credits != CRED_MAX)) begin
        r_credits <= r_credits + 4'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_HOLD;
      S_HOLD: if (w_tail_xfer || w_expire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs; grant and busy come straight from registered state.
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_grant[i] = (r_state == S_HOLD) && (r_gidx == 3'(i));
    end
    w_xfer      = (|(w_grant & req)) && (r_credits != 4'd0);
    grant       = w_grant;
    xfer        = w_xfer;
    busy        = (r_state == S_HOLD);
    credits     = r_credits;
    timeout_err = r_timeout_err;
  end

endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Directed bench for wormhole_output_allocator: arbitration, packet hold,
// credit gating, watchdog revocation, header filtering and mid-packet reset.
module tb_wormhole_output_allocator;

  localparam logic [2:0] H = 3'b001;
  localparam logic [2:0] B = 3'b010;
  localparam logic [2:0] T = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [14:0] flit_id;
  logic [11:0] timeout_cycles;
  logic        credit_return;
  logic [4:0]  grant;
  logic        xfer;
  logic        busy;
  logic [3:0]  credits;
  logic        timeout_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic terr_seen;

  always #5 clk = ~clk;

  wormhole_output_allocator #(.CREDITS(4), .NREQ(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .flit_id        (flit_id),
    .timeout_cycles (timeout_cycles),
    .credit_return  (credit_return),
    .grant          (grant),
    .xfer           (xfer),
    .busy           (busy),
    .credits        (credits),
    .timeout_err    (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input int i, input logic [2:0] f);
    flit_id[3*i +: 3] = f;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req           = '0;
    flit_id       = '0;
    credit_return = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    timeout_cycles = 12'd0;
    do_reset();

    // Reset values, then L+N headers: L wins, 3 flits move, N follows after a bubble.
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_credits", 32'(credits), 32'd4);
    check("rst_terr", 32'(timeout_err), 32'h0);
    req = 5'b00011;
    set_flit(0, H);
    set_flit(1, H);
    #1 check("idle_noxfer", 32'(xfer), 32'h0);
    tick();
    check("t1_grant_l", 32'(grant), 32'h01);
    check("t1_busy", 32'(busy), 32'h1);
    set_flit(0, B);
    #1 check("t1_xfer_b1", 32'(xfer), 32'h1);
    tick();
    check("t1_cred3", 32'(credits), 32'd3);
    tick();
    check("t1_cred2", 32'(credits), 32'd2);
    set_flit(0, T);
    #1 check("t1_xfer_tail", 32'(xfer), 32'h1);
    tick();
    check("t1_release", 32'(grant), 32'h0);
    check("t1_idle_busy", 32'(busy), 32'h0);
    check("t1_cred1", 32'(credits), 32'd1);
    req[0] = 1'b0;
    tick();
    check("t1_grant_n", 32'(grant), 32'h02);

    // Round robin: every requester always has a 1-header+1-tail packet.
    do_reset();
    req = 5'b11111;
    for (int i = 0; i < 5; i++) set_flit(i, H);
    credit_return = 1'b1;
    for (int p = 0; p < 10; p++) begin
      #1 check("rr_idle", 32'(grant), 32'h0);
      tick();
      check("rr_grant", 32'(grant), 32'(1) << (p % 5));
      set_flit(p % 5, T);
      #1 check("rr_xfer", 32'(xfer), 32'h1);
      tick();
      set_flit(p % 5, H);
    end
    check("rr_credits", 32'(credits), 32'd4);

    // Credit stall on E.
    do_reset();
    req = 5'b00100;
    set_flit(2, H);
    tick();
    check("cs_grant", 32'(grant), 32'h04);
    set_flit(2, B);
    for (int k = 0; k < 4; k++) begin
      #1 check("cs_xfer", 32'(xfer), 32'h1);
      tick();
    end
    check("cs_cred0", 32'(credits), 32'd0);
    #1 check("cs_stall", 32'(xfer), 32'h0);
    check("cs_hold", 32'(grant), 32'h04);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("cs_cred_ret", 32'(credits), 32'd1);
    #1 check("cs_one_xfer", 32'(xfer), 32'h1);
    tick();
    check("cs_cred0b", 32'(credits), 32'd0);
    #1 check("cs_stall2", 32'(xfer), 32'h0);
    credit_return = 1'b1;
    tick();
    check("cs_cred1", 32'(credits), 32'd1);
    set_flit(2, T);
    #1 check("cs_tail_xfer", 32'(xfer), 32'h1);
    tick();
    credit_return = 1'b0;
    check("cs_simul", 32'(credits), 32'd1);
    check("cs_release", 32'(grant), 32'h0);
    req = '0;

    // Watchdog: W granted, W drops, S header waits.
    do_reset();
    timeout_cycles = 12'd8;
    req = 5'b01000;
    set_flit(3, H);
    tick();
    check("wd_grant_w", 32'(grant), 32'h08);
    req = 5'b10000;
    set_flit(4, H);
    for (int k = 0; k < 7; k++) tick();
    check("wd_still_held", 32'(grant), 32'h08);
    check("wd_no_err_yet", 32'(timeout_err), 32'h0);
    tick();
    check("wd_revoked", 32'(grant), 32'h0);
    check("wd_busy", 32'(busy), 32'h0);
    check("wd_err", 32'(timeout_err), 32'h1);
    check("wd_credits", 32'(credits), 32'd4);
    tick();
    check("wd_grant_s", 32'(grant), 32'h10);
    check("wd_err_pulse", 32'(timeout_err), 32'h0);
    set_flit(4, T);
    #1 check("wd_s_xfer", 32'(xfer), 32'h1);
    tick();
    check("wd_s_release", 32'(grant), 32'h0);
    timeout_cycles = 12'd0;
    req = 5'b01000;
    set_flit(3, H);
    tick();
    check("wd0_grant_w", 32'(grant), 32'h08);
    req = '0;
    terr_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      terr_seen = terr_seen | timeout_err;
    end
    check("wd0_hold", 32'(grant), 32'h08);
    check("wd0_no_err", 32'(terr_seen), 32'h0);

    // Non-header flits never win.
    do_reset();
    req = 5'b00100;
    set_flit(2, B);
    tick();
    check("nh_no_grant", 32'(grant), 32'h0);
    tick();
    check("nh_no_grant2", 32'(grant), 32'h0);
    check("nh_idle", 32'(busy), 32'h0);
    req[4] = 1'b1;
    set_flit(4, H);
    tick();
    check("nh_grant_s", 32'(grant), 32'h10);

    // Reset in the middle of an N packet, after an L packet moved the pointer.
    do_reset();
    req = 5'b00001;
    set_flit(0, H);
    tick();
    check("mr_grant_l", 32'(grant), 32'h01);
    set_flit(0, T);
    tick();
    req = 5'b00010;
    set_flit(1, H);
    tick();
    check("mr_grant_n", 32'(grant), 32'h02);
    set_flit(1, B);
    #1 check("mr_xfer", 32'(xfer), 32'h1);
    tick();
    check("mr_cred2", 32'(credits), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_grant0", 32'(grant), 32'h0);
    check("mr_busy0", 32'(busy), 32'h0);
    check("mr_credits", 32'(credits), 32'd4);
    req = 5'b00011;
    set_flit(0, H);
    set_flit(1, H);
    tick();
    check("mr_ptr_reset", 32'(grant), 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
